q_measurement_mc: RTL and testbench

Q_MEASUREMENT_MC -- requirements
Module: q_measurement_mc

---
 rtl/q_meas_pkg.sv | 24 ++
 rtl/q_channel.sv | 130 +++++++++++++
 rtl/q_measurement_mc.sv | 113 +++++++++++
 tb/tb_q_measurement_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/q_meas_pkg.sv
// q_meas_pkg
// Shared definitions for the multi-channel charge measurement block:
// per-channel state encoding, parameter defaults and a helper that sizes
// the channel index bus.
package q_meas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ch_state_t;

    localparam int N_CH_DEF        = 4;
    localparam int BUS_WIDTH_DEF   = 10;
    localparam int CNT_WIDTH_DEF   = 8;
    localparam int WTD_WIDTH_DEF   = 2;
    localparam int Q_PER_PULSE_DEF = 30;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/q_channel.sv
// q_channel
// One pulse channel: 2-flop synchroniser plus edge register, saturating
// pulse counter, inactivity watchdog and the IDLE/COUNT/DONE sequencer.
//
// State table
//   state | meaning
//   IDLE  | waiting for the first rising edge of a burst
//   COUNT | counting edges; watchdog runs down while the input is low
//   DONE  | burst finished, count frozen until the result is accepted
//
// Ports
//   clk, rst   system clock, async active-high reset
//   start      level enable; low clears the channel to IDLE
//   q_in       asynchronous pulse input
//   ack        result of this channel accepted downstream
//   done       channel holds a finished count
//   count      pulse count (saturating)
//   sat        counter overflowed during this burst
module q_channel
    import q_meas_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int WTD_WIDTH = WTD_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 q_in,
    input  logic                 ack,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    logic       sync_1, sync_2, edge_q, armed;
    logic [1:0] fill;
    logic       rise;

    ch_state_t              state, state_n;
    logic [CNT_WIDTH-1:0]   cnt_n;
    logic [WTD_WIDTH-1:0]   wtd, wtd_n;
    logic                   sat_n;

    // fill tracks how many samples of the real input have reached sync_2.
    // armed requires the synchronised input to have been seen low after
    // that, so an input already high when reset releases never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            edge_q <= 1'b0;
            fill   <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync_1 <= q_in;
            sync_2 <= sync_1;
            edge_q <= sync_2;
            fill   <= {fill[0], 1'b1};
            if (fill[1] && !sync_2)
                armed <= 1'b1;
        end
    end

    assign rise = armed & sync_2 & ~edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            wtd   <= '1;
            sat   <= 1'b0;
        end else begin
            state <= state_n;
            count <= cnt_n;
            wtd   <= wtd_n;
            sat   <= sat_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = count;
        wtd_n   = wtd;
        sat_n   = sat;
        if (!start) begin
            state_n = IDLE;
            cnt_n   = '0;
            wtd_n   = '1;
            sat_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = COUNT;
                        cnt_n   = CNT_WIDTH'(1);
                        wtd_n   = '1;
                    end
                end
                COUNT: begin
                    // A rising edge in the timeout cycle keeps the burst alive.
                    if (rise) begin
                        wtd_n = '1;
                        if (count == '1)
                            sat_n = 1'b1;
                        else
                            cnt_n = count + CNT_WIDTH'(1);
                    end else if (sync_2) begin
                        wtd_n = '1;
                    end else if (wtd == '0) begin
                        state_n = DONE;
                    end else begin
                        wtd_n = wtd - WTD_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        wtd_n   = '1;
                        sat_n   = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign done = (state == DONE);

endmodule

// File: rtl/q_measurement_mc.sv
// q_measurement_mc
// Multi-channel pulse-count charge measurement. Each channel counts a burst
// of pulses; finished channels are served round-robin into a registered
// valid/ready result carrying channel index, charge and saturation flag.
//
// Ports
//   clk, rst      system clock, async active-high reset
//   start         level enable; low clears all channels and the result
//   q_serialized  asynchronous pulse trains, one bit per channel
//   out_valid     result available
//   out_ready     consumer accepts result
//   out_ch        channel index of the result
//   out_q         charge = count * Q_PER_PULSE, clamped to all-ones
//   out_sat       count or charge overflowed
module q_measurement_mc
    import q_meas_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int WTD_WIDTH   = WTD_WIDTH_DEF,
    parameter int Q_PER_PULSE = Q_PER_PULSE_DEF,
    localparam int CH_W       = ch_idx_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_CH-1:0]      q_serialized,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [BUS_WIDTH-1:0] out_q,
    output logic                 out_sat
);

    localparam logic [63:0] Q_MAX = (64'd1 << BUS_WIDTH) - 64'd1;

    logic [N_CH-1:0]      ch_done, ch_sat, ch_ack, held, req;
    logic [CNT_WIDTH-1:0] ch_cnt [N_CH];
    logic [CH_W-1:0]      rr_ptr, gnt_idx;
    logic                 gnt_found, slot_free;
    logic [63:0]          charge;
    logic                 over;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        q_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .WTD_WIDTH (WTD_WIDTH)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .q_in  (q_serialized[i]),
            .ack   (ch_ack[i]),
            .done  (ch_done[i]),
            .count (ch_cnt[i]),
            .sat   (ch_sat[i])
        );
    end

    // The channel whose result sits in the output register stays DONE until
    // accepted, so it is masked from arbitration meanwhile.
    always_comb begin
        held = '0;
        if (out_valid)
            held[out_ch] = 1'b1;
    end

    assign req       = ch_done & ~held;
    assign ch_ack    = held & {N_CH{out_ready}};
    assign slot_free = ~out_valid | out_ready;

    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

    assign charge = 64'(ch_cnt[gnt_idx]) * 64'(Q_PER_PULSE);
    assign over   = (charge > Q_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_q     <= '0;
            out_sat   <= 1'b0;
            rr_ptr    <= CH_W'(N_CH - 1);
        end else if (!start) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_q     <= '0;
            out_sat   <= 1'b0;
        end else if (slot_free) begin
            out_valid <= gnt_found;
            if (gnt_found) begin
                out_ch  <= gnt_idx;
                out_q   <= over ? '1 : charge[BUS_WIDTH-1:0];
                out_sat <= ch_sat[gnt_idx] | over;
                rr_ptr  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_q_measurement_mc.sv
module tb_q_measurement_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, ready_a, valid_a, sat_a;
    logic [3:0] qa;
    logic [1:0] ch_a;
    logic [9:0] q_a;
    logic       start_b, ready_b, valid_b, sat_b;
    logic [3:0] qb;
    logic [1:0] ch_b;
    logic [9:0] q_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    q_measurement_mc #(.N_CH(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start_a),
        .q_serialized (qa),
        .out_valid    (valid_a),
        .out_ready    (ready_a),
        .out_ch       (ch_a),
        .out_q        (q_a),
        .out_sat      (sat_a)
    );

    q_measurement_mc #(.N_CH(4), .CNT_WIDTH(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start_b),
        .q_serialized (qb),
        .out_valid    (valid_b),
        .out_ready    (ready_b),
        .out_ch       (ch_b),
        .out_q        (q_b),
        .out_sat      (sat_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulses(input logic [3:0] mask_a, input logic [3:0] mask_b, input int n);
        for (int i = 0; i < n; i++) begin
            qa = qa | mask_a;
            qb = qb | mask_b;
            repeat (2) @(negedge clk);
            qa = qa & ~mask_a;
            qb = qb & ~mask_b;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!valid_a && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, valid_a, 1);
    endtask

    task automatic expect_res(input string tag, input int ch, input int q, input int sat);
        check({tag, "_valid"}, valid_a, 1);
        check({tag, "_ch"}, ch_a, ch);
        check({tag, "_q"}, q_a, q);
        check({tag, "_sat"}, sat_a, sat);
    endtask

    task automatic expect_idle(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_a) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1; qa = '0; qb = '0;
        #12;
        check("rst_valid", valid_a, 0);
        check("rst_ch", ch_a, 0);
        check("rst_q", q_a, 0);
        check("rst_sat", sat_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // three pulses on ch0
        pulses(4'b0001, 4'b0000, 3);
        wait_valid("ch0_3p_wait", 40);
        expect_res("ch0_3p", 0, 90, 0);
        @(negedge clk);
        check("ch0_3p_accepted", valid_a, 0);
        expect_idle("ch0_3p_single", 20);

        // ch1 (2 pulses) and ch2 (3 pulses) finish together: ch1 first
        pulses(4'b0100, 4'b0000, 1);
        pulses(4'b0110, 4'b0000, 2);
        wait_valid("rr1_wait", 40);
        expect_res("rr1_first", 1, 60, 0);
        @(negedge clk);
        expect_res("rr1_second", 2, 90, 0);
        @(negedge clk);
        check("rr1_drain", valid_a, 0);

        // last grant ch2: ch3 ahead of ch1
        pulses(4'b1000, 4'b0000, 1);
        pulses(4'b1010, 4'b0000, 1);
        wait_valid("rr2_wait", 40);
        expect_res("rr2_first", 3, 60, 0);
        @(negedge clk);
        expect_res("rr2_second", 1, 30, 0);
        @(negedge clk);
        check("rr2_drain", valid_a, 0);

        // last grant ch1: ch2 ahead of ch0 (wraparound)
        pulses(4'b0001, 4'b0000, 1);
        pulses(4'b0101, 4'b0000, 1);
        wait_valid("rr3_wait", 40);
        expect_res("rr3_first", 2, 30, 0);
        @(negedge clk);
        expect_res("rr3_second", 0, 60, 0);
        @(negedge clk);
        check("rr3_drain", valid_a, 0);

        // charge overflow (40 pulses) and count overflow (CNT_WIDTH=4, 20 pulses)
        ready_b = 1'b0;
        pulses(4'b0001, 4'b0001, 20);
        pulses(4'b0001, 4'b0000, 20);
        wait_valid("ovf_wait", 40);
        expect_res("ovf_charge", 0, 1023, 1);
        check("ovf_cnt_valid", valid_b, 1);
        check("ovf_cnt_ch", ch_b, 0);
        check("ovf_cnt_q", q_b, 450);
        check("ovf_cnt_sat", sat_b, 1);
        ready_b = 1'b1;
        @(negedge clk);
        check("ovf_a_accepted", valid_a, 0);
        check("ovf_b_accepted", valid_b, 0);

        // backpressure on ch3; pulses during DONE are dropped
        ready_a = 1'b0;
        pulses(4'b1000, 4'b0000, 2);
        wait_valid("bp_wait", 40);
        for (int i = 0; i < 10; i++) begin
            qa[3] = ((i % 4) < 2) && (i < 8);
            expect_res("bp_hold", 3, 60, 0);
            @(negedge clk);
        end
        qa[3] = 1'b0;
        ready_a = 1'b1;
        @(negedge clk);
        check("bp_accepted", valid_a, 0);
        expect_idle("bp_no_recount", 20);

        // start dropped mid-count
        pulses(4'b0010, 4'b0000, 2);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        expect_idle("start_mid_count", 30);
        pulses(4'b0010, 4'b0000, 1);
        wait_valid("start_restart_wait", 40);
        expect_res("start_restart", 1, 30, 0);
        @(negedge clk);

        // start dropped while a result is pending
        ready_a = 1'b0;
        pulses(4'b0100, 4'b0000, 1);
        wait_valid("start_pend_wait", 40);
        expect_res("start_pend", 2, 30, 0);
        start_a = 1'b0;
        @(negedge clk);
        check("start_drop_valid", valid_a, 0);
        start_a = 1'b1;
        ready_a = 1'b1;
        expect_idle("start_discarded", 30);

        // async reset with a pending result and ch0 input high mid-count
        ready_a = 1'b0;
        pulses(4'b0010, 4'b0000, 1);
        wait_valid("arst_pend_wait", 40);
        expect_res("arst_pend", 1, 30, 0);
        qa[0] = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", valid_a, 0);
        check("arst_ch", ch_a, 0);
        check("arst_q", q_a, 0);
        check("arst_sat", sat_a, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_a = 1'b1;
        repeat (6) @(negedge clk);
        qa[0] = 1'b0;
        expect_idle("arst_no_spurious", 30);

        // pointer back at N_CH-1: ch0 ahead of ch3
        pulses(4'b0001, 4'b0000, 1);
        pulses(4'b1001, 4'b0000, 1);
        wait_valid("arst_rr_wait", 40);
        expect_res("arst_rr_first", 0, 60, 0);
        @(negedge clk);
        expect_res("arst_rr_second", 3, 30, 0);
        @(negedge clk);
        check("arst_rr_drain", valid_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
